encoder_4x2_sync: RTL

- Reverse direction of the team's 2x4 gate decoder: takes the four active-low select lines D[3:0] and recovers the 2-bit code {A,B}.
- Lines may be asynchronous, for example from a panel or another clock domain. The block synchronises them, requires a stable one-cold pattern, then reports the code once through a valid/ready handshake.
- Flags illegal multi-low patterns.
- Sits between external select lines and the control logic that consumes {A,B}.

---
 rtl/encoder_pkg.sv | 39 +++
 rtl/encoder_4x2_sync_sync_nff.sv | 26 ++
 rtl/encoder_4x2_sync.sv | 120 ++++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Shared types and helpers for the 4-to-2 active-low select encoder.
package encoder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] D_IDLE = 4'b1111;

  typedef struct packed {
    logic       onecold;
    logic [1:0] code;
  } code_info_t;

  function automatic code_info_t onecold_to_code(input logic [3:0] d);
    code_info_t r;
    r.onecold = 1'b1;
    r.code    = 2'b00;
    case (d)
      4'b1110: r.code = 2'b00;
      4'b1101: r.code = 2'b01;
      4'b1011: r.code = 2'b10;
      4'b0111: r.code = 2'b11;
      default: r.onecold = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_multilow(input logic [3:0] d);
    logic [2:0] zeros;
    zeros = '0;
    for (int i = 0; i < 4; i++) zeros = zeros + {2'b00, ~d[i]};
    return (zeros >= 3'd2);
  endfunction

endpackage

// File: rtl/encoder_4x2_sync_sync_nff.sv
// N-bit multi-flop synchroniser with asynchronous active-low reset to RST_VAL.
module sync_nff #(
  parameter int           W       = 4,
  parameter int           STAGES  = 2,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= RST_VAL;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/encoder_4x2_sync.sv
// Synchronises active-low select lines, waits for a stable one-cold pattern,
// and reports its 2-bit code once per press.
module encoder_4x2_sync
  import encoder_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] D,
  input  logic       enable,
  output logic       A,
  output logic       B,
  output logic       valid,
  input  logic       ready,
  output logic       error,
  output state_t     o_dbg_state
);

  localparam int                CNT_W      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  STABLE_CNT = CNT_W'(STABLE_CYCLES);

  logic [3:0]       w_d_s;
  code_info_t       w_info;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_cand, w_cand_nxt;
  logic             r_a, r_b, w_a_nxt, w_b_nxt;
  logic             r_error;

  sync_nff #(
    .W       (4),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (D_IDLE)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (D),
    .o_q   (w_d_s)
  );

  assign w_info = onecold_to_code(w_d_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cand  <= D_IDLE;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_error <= enable && is_multilow(w_d_s);
    end
  end

  // valid/ready: in HOLD the code sits on {A,B} with valid high; the transfer
  // happens on the first rising edge with valid && ready, after which valid drops.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    case (r_state)
      IDLE: begin
        if (enable && w_info.onecold) begin
          w_cand_nxt = w_d_s;
          w_cnt_nxt  = CNT_W'(1);
          if (STABLE_CYCLES == 1) begin
            w_state_nxt        = HOLD;
            {w_a_nxt, w_b_nxt} = w_info.code;
          end else begin
            w_state_nxt = SETTLE;
          end
        end
      end
      SETTLE: begin
        // A change on the completing edge still aborts.
        if ((w_d_s != r_cand) || !enable) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (w_cnt_nxt == STABLE_CNT) begin
            w_state_nxt        = HOLD;
            {w_a_nxt, w_b_nxt} = w_info.code;
          end
        end
      end
      HOLD: begin
        if (ready) w_state_nxt = RELEASE;
      end
      RELEASE: begin
        // Held lines must return to idle before the next report.
        if ((w_d_s == D_IDLE) || !enable) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign A           = r_a;
  assign B           = r_b;
  assign valid       = (r_state == HOLD);
  assign error       = r_error;
  assign o_dbg_state = r_state;

endmodule
